// File: rtl/ram_target_if.sv
// Host/memory signal bundle of the RAM target. slave = target view,
// master = host plus memory view.
interface ram_target_if #(
  parameter int ADDR_W = 16
);
  logic              ram_cs;
  logic [15:0]       bus_dq_in;
  logic [1:0]        bus_rwds_in;
  logic [15:0]       bus_dq_out;
  logic              bus_dq_oe;
  logic              bus_rwds_out;
  logic              bus_rwds_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [15:0]       mem_wdat;
  logic [1:0]        mem_be;
  logic              mem_re;
  logic [15:0]       mem_rdat;

  modport slave (
    input  ram_cs, bus_dq_in, bus_rwds_in, mem_rdat,
    output bus_dq_out, bus_dq_oe, bus_rwds_out, bus_rwds_oe,
    output mem_addr, mem_we, mem_wdat, mem_be, mem_re
  );

  modport master (
    output ram_cs, bus_dq_in, bus_rwds_in, mem_rdat,
    input  bus_dq_out, bus_dq_oe, bus_rwds_out, bus_rwds_oe,
    input  mem_addr, mem_we, mem_wdat, mem_be, mem_re
  );
endinterface

// File: rtl/ram_target.sv
// HyperRAM-style bus target: 3-word command/address phase, programmable
// latency, unbounded read/write bursts onto a simple synchronous memory port.
module ram_target #(
  parameter int          ADDR_W  = 16,
  parameter int          LAT_RST = 6,
  parameter logic [15:0] ID0     = 16'h0C81
) (
  input logic         clk,
  input logic         rst_n,
  ram_target_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CA, LAT, WR, RD, REGW, HOLD} state_t;

  state_t            state_reg;
  logic              ca_second_reg;
  logic              rd_reg;
  logic              rg_reg;
  logic [28:0]       addr_hi_reg;
  logic [4:0]        lat_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       dq_reg;
  logic [4:0]        cr0_reg;

  logic        active;
  logic        in_ca;
  logic        mem_re;
  logic        mem_we;
  logic        reg_adv;
  logic [3:0]  lat_eff;
  logic [4:0]  lat_l;
  logic [15:0] reg_word;

  // Deselect and reset gate every strobe and drive in the same cycle.
  assign active  = rst_n & ~bus.ram_cs;
  assign in_ca   = (state_reg == IDLE) || (state_reg == CA);
  assign lat_eff = (cr0_reg[3:0] < 4'd2) ? 4'd2 : cr0_reg[3:0];
  assign lat_l   = cr0_reg[4] ? {lat_eff, 1'b0} : {1'b0, lat_eff};

  // Memory reads run two words ahead of the bus: prefetch starts in the
  // last two latency cycles and then streams every cycle.
  assign mem_re  = active & rd_reg & ~rg_reg &
                   (((state_reg == LAT) && (lat_cnt_reg <= 5'd1)) || (state_reg == RD));
  assign reg_adv = active & rd_reg & rg_reg &
                   (((state_reg == LAT) && (lat_cnt_reg == 5'd0)) || (state_reg == RD));
  assign mem_we  = active & (state_reg == WR);

  always_comb begin
    reg_word = 16'h0000;
    if (addr_reg == ADDR_W'(0))
      reg_word = {11'd0, cr0_reg};
    else if (addr_reg == ADDR_W'(1))
      reg_word = ID0;
  end

  assign bus.bus_dq_oe    = active & (state_reg == RD);
  assign bus.bus_dq_out   = bus.bus_dq_oe ? dq_reg : 16'h0000;
  assign bus.bus_rwds_oe  = active & (in_ca || (state_reg == RD));
  assign bus.bus_rwds_out = active & ((state_reg == RD) || (in_ca && cr0_reg[4]));
  assign bus.mem_addr     = addr_reg;
  assign bus.mem_we       = mem_we;
  assign bus.mem_re       = mem_re;
  assign bus.mem_wdat     = mem_we ? bus.bus_dq_in : 16'h0000;
  assign bus.mem_be       = mem_we ? ~bus.bus_rwds_in : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ca_second_reg <= 1'b0;
      rd_reg        <= 1'b0;
      rg_reg        <= 1'b0;
      addr_hi_reg   <= '0;
      lat_cnt_reg   <= '0;
      addr_reg      <= '0;
      dq_reg        <= '0;
      cr0_reg       <= {1'b0, 4'(LAT_RST)};
    end else begin
      dq_reg <= reg_adv ? reg_word : bus.mem_rdat;
      if (mem_re || mem_we || reg_adv)
        addr_reg <= addr_reg + ADDR_W'(1);

      if (bus.ram_cs) begin
        state_reg <= IDLE;
      end else begin
        unique case (state_reg)
          IDLE: begin
            rd_reg                    <= bus.bus_dq_in[15];
            rg_reg                    <= bus.bus_dq_in[14];
            addr_hi_reg[28:16]        <= bus.bus_dq_in[12:0];
            ca_second_reg             <= 1'b0;
            state_reg                 <= CA;
          end
          CA: begin
            if (!ca_second_reg) begin
              addr_hi_reg[15:0] <= bus.bus_dq_in;
              ca_second_reg     <= 1'b1;
            end else begin
              addr_reg    <= ADDR_W'({addr_hi_reg, bus.bus_dq_in[2:0]});
              lat_cnt_reg <= lat_l - 5'd1;
              state_reg   <= (!rd_reg && rg_reg) ? REGW : LAT;
            end
          end
          LAT: begin
            if (lat_cnt_reg == 5'd0)
              state_reg <= rd_reg ? RD : WR;
            else
              lat_cnt_reg <= lat_cnt_reg - 5'd1;
          end
          REGW: begin
            if (addr_reg == ADDR_W'(0))
              cr0_reg <= bus.bus_dq_in[4:0];
            state_reg <= HOLD;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
